// File: rtl/cpu_pkg.sv
// Shared CPU constants: architectural register indices and
// default datapath widths for the decode-stage register file.
package cpu_pkg;

  localparam int CPU_DATA_W = 16;
  localparam int CPU_ADDR_W = 4;

  localparam int REG_SP   = 8;
  localparam int REG_T    = 9;
  localparam int REG_IH   = 10;
  localparam int REG_ZERO = 15;

endpackage

// File: rtl/sb_counter.sv
// One scoreboard slot: saturating up/down count of outstanding
// writes to a single register, with synchronous clear.
module sb_counter #(
  parameter  int CNT_MAX = 3,
  localparam int CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !dec && cnt_q != CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec && !inc && cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with write-back bypass, per-register
// outstanding-write scoreboard for RAW stalls, and a debug port.
module regfile_scoreboard
  import cpu_pkg::*;
#(
  parameter  int DATA_W   = CPU_DATA_W,
  parameter  int NUM_REGS = 16,
  parameter  int NUM_READ = 2,
  parameter  int ZERO_IDX = REG_ZERO,
  parameter  int CNT_MAX  = 3,
  localparam int ADDR_W   = $clog2(NUM_REGS),
  localparam int CNT_W    = $clog2(CNT_MAX + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_READ*ADDR_W-1:0] rd_addr,
  output logic [NUM_READ*DATA_W-1:0] rd_data,
  output logic [NUM_READ-1:0]        rd_busy,
  input  logic                       wb_en,
  input  logic [ADDR_W-1:0]          wb_addr,
  input  logic [DATA_W-1:0]          wb_data,
  input  logic                       issue_en,
  input  logic [ADDR_W-1:0]          issue_addr,
  output logic                       issue_ready,
  input  logic                       flush,
  output logic                       stall,
  input  logic [NUM_READ-1:0]        rd_check,
  input  logic [ADDR_W-1:0]          dbg_addr,
  output logic [DATA_W-1:0]          dbg_data
);

  localparam int NSLOT = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZA = ADDR_W'(ZERO_IDX);

  function automatic logic [NSLOT-1:0] valid_mask();
    logic [NSLOT-1:0] m;
    for (int i = 0; i < NSLOT; i++) begin
      m[i] = (i < NUM_REGS);
    end
    return m;
  endfunction

  localparam logic [NSLOT-1:0] VALID = valid_mask();

  logic [DATA_W-1:0] regs_q [NSLOT];
  logic [DATA_W-1:0] regs_d [NSLOT];
  logic [CNT_W-1:0]  cnt    [NSLOT];
  logic [DATA_W-1:0] dbg_q;
  logic [DATA_W-1:0] dbg_d;
  logic              wb_hit;
  logic              issue_fire;

  assign wb_hit = wb_en && wb_addr != ZA && cnt[wb_addr] != '0;

  // A write landing this cycle frees one slot for a same-reg issue.
  assign issue_ready = (cnt[issue_addr] != CNT_W'(CNT_MAX))
                    || (wb_hit && wb_addr == issue_addr);

  assign issue_fire = issue_en && issue_ready && issue_addr != ZA;

  for (genvar r = 0; r < NSLOT; r++) begin : g_sb
    if (r < NUM_REGS && r != ZERO_IDX) begin : g_cnt
      logic inc_r;
      logic dec_r;
      assign inc_r = issue_fire && issue_addr == ADDR_W'(r);
      assign dec_r = wb_hit && wb_addr == ADDR_W'(r);
      sb_counter #(
        .CNT_MAX(CNT_MAX)
      ) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(inc_r),
        .dec(dec_r),
        .clr(flush),
        .cnt(cnt[r])
      );
    end else begin : g_none
      assign cnt[r] = '0;
    end
  end

  always_comb begin
    for (int r = 0; r < NSLOT; r++) begin
      regs_d[r] = regs_q[r];
      if (wb_en && wb_addr == ADDR_W'(r) && VALID[r] && r != ZERO_IDX) begin
        regs_d[r] = wb_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [CNT_W-1:0]  c;
      a = rd_addr[k*ADDR_W +: ADDR_W];
      d = regs_q[a];
      if (wb_en && wb_addr == a) d = wb_data;
      if (a == ZA || !VALID[a]) d = '0;
      c = cnt[a] - CNT_W'(wb_hit && wb_addr == a);
      rd_data[k*DATA_W +: DATA_W] = d;
      rd_busy[k] = (a != ZA) && (c != '0);
    end
  end

  assign stall = |(rd_busy & rd_check);

  assign dbg_d = regs_q[dbg_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NSLOT; r++) begin
        regs_q[r] <= '0;
      end
      dbg_q <= '0;
    end else begin
      for (int r = 0; r < NSLOT; r++) begin
        regs_q[r] <= regs_d[r];
      end
      dbg_q <= dbg_d;
    end
  end

  assign dbg_data = dbg_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: reset, bypass, zero reg,
// scoreboard saturation, simultaneous issue/wb, and flush.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [7:0]  rd_addr;
  logic [31:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        issue_en;
  logic [3:0]  issue_addr;
  logic        issue_ready;
  logic        flush;
  logic        stall;
  logic [1:0]  rd_check;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  int n_checks = 0;
  int n_fail   = 0;

  regfile_scoreboard dut (
    .clk(clk),
    .rst(rst),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .rd_busy(rd_busy),
    .wb_en(wb_en),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .issue_en(issue_en),
    .issue_addr(issue_addr),
    .issue_ready(issue_ready),
    .flush(flush),
    .stall(stall),
    .rd_check(rd_check),
    .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; inputs are then driven at +1 and checked at +2.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_en = 0; wb_addr = 0; wb_data = 0;
    issue_en = 0; issue_addr = 0;
    flush = 0; rd_check = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle();
    rd_addr = {4'd1, 4'd0}; dbg_addr = 0; issue_addr = 4'd2;
    step(); step(); #1;
    n_checks++;
    if (rd_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_rd_data got %h want %h", rd_data, 32'h0);
    end
    n_checks++;
    if (rd_busy !== 2'b00 || stall !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy got %b/%b want 00/0", rd_busy, stall);
    end
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_issue_ready got %b want 1", issue_ready);
    end
    n_checks++;
    if (dbg_data !== 16'h0) begin
      n_fail++; $display("FAIL reset_dbg got %h want 0000", dbg_data);
    end
    rst = 0;
    step();
  endtask

  task automatic test_bypass();
    wb_en = 1; wb_addr = 3; wb_data = 16'h1234;
    rd_addr = {4'd0, 4'd3}; dbg_addr = 3;
    #1;
    n_checks++;
    if (rd_data[15:0] !== 16'h1234) begin
      n_fail++; $display("FAIL bypass_same_cycle got %h want 1234", rd_data[15:0]);
    end
    step(); idle(); #1;
    n_checks++;
    if (rd_data[15:0] !== 16'h1234) begin
      n_fail++; $display("FAIL bypass_stored got %h want 1234", rd_data[15:0]);
    end
    n_checks++;
    if (dbg_data !== 16'h0000) begin
      n_fail++; $display("FAIL dbg_latency got %h want 0000", dbg_data);
    end
    step(); #1;
    n_checks++;
    if (dbg_data !== 16'h1234) begin
      n_fail++; $display("FAIL dbg_r3 got %h want 1234", dbg_data);
    end
  endtask

  task automatic test_zero();
    wb_en = 1; wb_addr = 15; wb_data = 16'hFFFF;
    rd_addr = {4'd15, 4'd3}; dbg_addr = 15;
    #1;
    n_checks++;
    if (rd_data[31:16] !== 16'h0) begin
      n_fail++; $display("FAIL zero_bypass got %h want 0000", rd_data[31:16]);
    end
    step(); idle(); #1;
    n_checks++;
    if (rd_data[31:16] !== 16'h0) begin
      n_fail++; $display("FAIL zero_read got %h want 0000", rd_data[31:16]);
    end
    step(); #1;
    n_checks++;
    if (dbg_data !== 16'h0) begin
      n_fail++; $display("FAIL zero_dbg got %h want 0000", dbg_data);
    end
    issue_en = 1; issue_addr = 15; rd_addr = {4'd0, 4'd15}; rd_check = 2'b01;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1) begin
      n_fail++; $display("FAIL zero_issue_ready got %b want 1", issue_ready);
    end
    step(); idle(); #1;
    n_checks++;
    if (rd_busy !== 2'b00 || stall !== 1'b0) begin
      n_fail++; $display("FAIL zero_issue_busy got %b/%b want 00/0", rd_busy, stall);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] v;
    rd_addr = {4'd0, 4'd2};
    for (int i = 0; i < 3; i++) begin
      issue_en = 1; issue_addr = 2;
      #1;
      n_checks++;
      if (issue_ready !== 1'b1) begin
        n_fail++; $display("FAIL sat_issue%0d got %b want 1", i, issue_ready);
      end
      step();
    end
    #1;
    n_checks++;
    if (issue_ready !== 1'b0) begin
      n_fail++; $display("FAIL sat_full got %b want 0", issue_ready);
    end
    step(); idle();
    rd_check = 2'b00; #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || stall !== 1'b0) begin
      n_fail++; $display("FAIL sat_masked got %b/%b want 1/0", rd_busy[0], stall);
    end
    rd_check = 2'b01; #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_fail++; $display("FAIL sat_stall got %b want 1", stall);
    end
    for (int i = 1; i <= 3; i++) begin
      v = 16'(i);
      wb_en = 1; wb_addr = 2; wb_data = v; issue_addr = 2;
      #1;
      n_checks++;
      if (issue_ready !== 1'b1) begin
        n_fail++; $display("FAIL sat_wb%0d_ready got %b want 1", i, issue_ready);
      end
      n_checks++;
      if (rd_busy[0] !== (i != 3) || stall !== (i != 3)) begin
        n_fail++; $display("FAIL sat_wb%0d_busy got %b/%b want %b", i,
                           rd_busy[0], stall, (i != 3));
      end
      n_checks++;
      if (rd_data[15:0] !== v) begin
        n_fail++; $display("FAIL sat_wb%0d_data got %h want %h", i, rd_data[15:0], v);
      end
      step();
    end
    idle(); rd_check = 2'b01; #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[15:0] !== 16'h0003) begin
      n_fail++; $display("FAIL sat_drained got %b/%h want 0/0003", rd_busy[0], rd_data[15:0]);
    end
    idle();
  endtask

  task automatic test_simul();
    rd_addr = {4'd0, 4'd8};
    issue_en = 1; issue_addr = 8;
    step();
    wb_en = 1; wb_addr = 8; wb_data = 16'hBEEF;
    #1;
    n_checks++;
    if (issue_ready !== 1'b1 || rd_busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL simul_same got %b/%b want 1/0", issue_ready, rd_busy[0]);
    end
    step(); idle(); #1;
    n_checks++;
    if (rd_busy[0] !== 1'b1 || rd_data[15:0] !== 16'hBEEF) begin
      n_fail++; $display("FAIL simul_after got %b/%h want 1/beef", rd_busy[0], rd_data[15:0]);
    end
    wb_en = 1; wb_addr = 8; wb_data = 16'hCAFE;
    step(); idle(); #1;
    n_checks++;
    if (rd_busy[0] !== 1'b0 || rd_data[15:0] !== 16'hCAFE) begin
      n_fail++; $display("FAIL simul_drain got %b/%h want 0/cafe", rd_busy[0], rd_data[15:0]);
    end
  endtask

  task automatic test_flush();
    rd_addr = {4'd4, 4'd1};
    issue_en = 1; issue_addr = 1;
    step();
    issue_addr = 4;
    step(); idle();
    flush = 1; wb_en = 1; wb_addr = 1; wb_data = 16'h00AA; rd_check = 2'b11;
    #1;
    n_checks++;
    if (rd_busy !== 2'b10 || stall !== 1'b1) begin
      n_fail++; $display("FAIL flush_cycle got %b/%b want 10/1", rd_busy, stall);
    end
    step(); idle(); rd_check = 2'b11; #1;
    n_checks++;
    if (rd_busy !== 2'b00 || stall !== 1'b0) begin
      n_fail++; $display("FAIL flush_after got %b/%b want 00/0", rd_busy, stall);
    end
    n_checks++;
    if (rd_data[15:0] !== 16'h00AA) begin
      n_fail++; $display("FAIL flush_write got %h want 00aa", rd_data[15:0]);
    end
    wb_en = 1; wb_addr = 4; wb_data = 16'h0055; issue_en = 1; issue_addr = 4;
    #1;
    n_checks++;
    if (rd_busy[1] !== 1'b0 || rd_data[31:16] !== 16'h0055) begin
      n_fail++; $display("FAIL stale_wb got %b/%h want 0/0055", rd_busy[1], rd_data[31:16]);
    end
    step(); idle(); #1;
    n_checks++;
    if (rd_busy[1] !== 1'b1) begin
      n_fail++; $display("FAIL stale_issue got %b want 1", rd_busy[1]);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_zero();
    test_saturate();
    test_simul();
    test_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
